alu_op_sequencer: RTL and testbench

- Sequences the ALU datapath between the operand FIFO (FIFO_IN) and the result FIFO (FIFO_OUT).
- Pops one CSR-built command word from FIFO_IN and issues it to the ALU core.
- Waits for ALU completion, then pushes {ID, result} to FIFO_OUT, honouring full backpressure.
- Processes one operation in flight at a time. Gated by a run enable from the CSR control register.

---
 rtl/alu_op_sequencer_if.sv | 46 ++++
 rtl/alu_op_sequencer.sv | 179 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer_if
// Bundles the sequencer's handshake and data signals: CSR run enable,
// FIFO_IN pop side, ALU issue/complete side, FIFO_OUT push side and status.
//   master : sequencer view (drives strobes, ALU operands, push data, status)
//   slave  : environment view (FIFOs, ALU core, CSR block)
// ---------------------------------------------------------------------------
interface alu_op_sequencer_if #(
    parameter int DATA_SIZE      = 16,
    parameter int ID_SIZE        = 8,
    parameter int OPERATION_SIZE = 2,
    parameter int RESULT_SIZE    = 17,
    parameter int CNT_SIZE       = 16
);
    localparam int FIFO_IN_WIDTH  = DATA_SIZE * 2 + ID_SIZE + OPERATION_SIZE;
    localparam int FIFO_OUT_WIDTH = ID_SIZE + RESULT_SIZE;

    logic                      run_en;
    logic                      empty_in;
    logic [FIFO_IN_WIDTH-1:0]  fifo_in_data;
    logic                      r_en_in;
    logic                      alu_start;
    logic [OPERATION_SIZE-1:0] alu_op;
    logic [DATA_SIZE-1:0]      alu_a;
    logic [DATA_SIZE-1:0]      alu_b;
    logic                      alu_done;
    logic [RESULT_SIZE-1:0]    alu_result;
    logic                      full_out;
    logic                      w_en_out;
    logic [FIFO_OUT_WIDTH-1:0] fifo_out_data;
    logic                      busy;
    logic [CNT_SIZE-1:0]       op_cnt;
    logic                      timeout_err;

    modport master (
        input  run_en, empty_in, fifo_in_data, alu_done, alu_result, full_out,
        output r_en_in, alu_start, alu_op, alu_a, alu_b, w_en_out,
               fifo_out_data, busy, op_cnt, timeout_err
    );

    modport slave (
        output run_en, empty_in, fifo_in_data, alu_done, alu_result, full_out,
        input  r_en_in, alu_start, alu_op, alu_a, alu_b, w_en_out,
               fifo_out_data, busy, op_cnt, timeout_err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
// Pops one command word from FIFO_IN, issues it to the ALU core, waits for
// completion and pushes {id, result} to FIFO_OUT under full backpressure.
// One operation in flight at a time, gated by the CSR run enable.
//
// Ports:
//   clk  : clock, all logic on rising edge
//   rst  : synchronous active-high reset
//   bus  : alu_op_sequencer_if.master (run_en, FIFO_IN pop, ALU issue/done,
//          FIFO_OUT push, busy, op_cnt, timeout_err)
//
// Build option: define ALU_TIMEOUT_EN to add a WAIT watchdog that pushes an
// all-ones result and pulses timeout_err after TIMEOUT_CYCLES WAIT cycles.
// Without it WAIT waits indefinitely and timeout_err is tied low.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for run_en and a non-empty FIFO_IN; pops on exit
// POP       | FIFO_IN read data valid; latch op/id/operands
// ISSUE     | one-cycle alu_start
// WAIT_DONE | waiting for alu_done (or watchdog expiry)
// PUSH      | waiting for !full_out, then push {id, result}
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int DATA_SIZE      = 16,
    parameter int ID_SIZE        = 8,
    parameter int OPERATION_SIZE = 2,
    parameter int RESULT_SIZE    = 17,
    parameter int CNT_SIZE       = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic               clk,
    input logic               rst,
    alu_op_sequencer_if.master bus
);
    localparam int FIFO_OUT_WIDTH = ID_SIZE + RESULT_SIZE;
    localparam int ID_LSB = OPERATION_SIZE;
    localparam int D0_LSB = ID_LSB + ID_SIZE;
    localparam int D1_LSB = D0_LSB + DATA_SIZE;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        ISSUE,
        WAIT_DONE,
        PUSH
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [OPERATION_SIZE-1:0] op_q;
    logic [ID_SIZE-1:0]        id_q;
    logic [DATA_SIZE-1:0]      a_q;
    logic [DATA_SIZE-1:0]      b_q;
    logic [RESULT_SIZE-1:0]    result_q;
    logic [RESULT_SIZE-1:0]    result_nxt;
    logic [FIFO_OUT_WIDTH-1:0] out_data_q;
    logic [CNT_SIZE-1:0]       op_cnt_q;
    logic                      r_en;
    logic                      start;
    logic                      w_en;
    logic                      ld_result;

`ifdef ALU_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    // Down-counter loaded on ISSUE; terminal count 0 is the last WAIT cycle.
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == ISSUE) begin
            tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
        end else if (state == WAIT_DONE && !bus.alu_done && tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - 1'b1;
        end
    end

    assign bus.timeout_err = tmo_hit & ~rst;
`else
    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_q       <= '0;
            id_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            out_data_q <= '0;
            op_cnt_q   <= '0;
        end else begin
            state <= state_nxt;
            if (state == POP) begin
                op_q <= bus.fifo_in_data[OPERATION_SIZE-1:0];
                id_q <= bus.fifo_in_data[ID_LSB +: ID_SIZE];
                a_q  <= bus.fifo_in_data[D0_LSB +: DATA_SIZE];
                b_q  <= bus.fifo_in_data[D1_LSB +: DATA_SIZE];
            end
            if (ld_result) begin
                result_q <= result_nxt;
            end
            if (w_en) begin
                out_data_q <= {id_q, result_q};
                op_cnt_q   <= op_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        r_en       = 1'b0;
        start      = 1'b0;
        w_en       = 1'b0;
        ld_result  = 1'b0;
        result_nxt = bus.alu_result;
`ifdef ALU_TIMEOUT_EN
        tmo_hit    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bus.run_en && !bus.empty_in) begin
                    r_en      = 1'b1;
                    state_nxt = POP;
                end
            end
            POP: begin
                state_nxt = ISSUE;
            end
            ISSUE: begin
                start     = 1'b1;
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                // A done arriving together with watchdog expiry wins.
                if (bus.alu_done) begin
                    ld_result = 1'b1;
                    state_nxt = PUSH;
                end
`ifdef ALU_TIMEOUT_EN
                else if (tmo_cnt == '0) begin
                    ld_result  = 1'b1;
                    result_nxt = '1;
                    tmo_hit    = 1'b1;
                    state_nxt  = PUSH;
                end
`endif
            end
            PUSH: begin
                if (!bus.full_out) begin
                    w_en      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Strobes are masked during reset so a discarded command never pops or pushes.
    assign bus.r_en_in   = r_en & ~rst;
    assign bus.alu_start = start & ~rst;
    assign bus.w_en_out  = w_en & ~rst;

    assign bus.alu_op = op_q;
    assign bus.alu_a  = a_q;
    assign bus.alu_b  = b_q;

    // Present the pending word while in PUSH, otherwise the last pushed word.
    assign bus.fifo_out_data = (state == PUSH) ? {id_q, result_q} : out_data_q;
    assign bus.busy          = (state != IDLE);
    assign bus.op_cnt        = op_cnt_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
    localparam int DATA_SIZE      = 16;
    localparam int ID_SIZE        = 8;
    localparam int OPERATION_SIZE = 2;
    localparam int RESULT_SIZE    = 17;
    localparam int CNT_SIZE       = 16;
    localparam int TIMEOUT_CYCLES = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_op_sequencer_if #(
        .DATA_SIZE(DATA_SIZE), .ID_SIZE(ID_SIZE), .OPERATION_SIZE(OPERATION_SIZE),
        .RESULT_SIZE(RESULT_SIZE), .CNT_SIZE(CNT_SIZE)
    ) bus ();

    alu_op_sequencer #(
        .DATA_SIZE(DATA_SIZE), .ID_SIZE(ID_SIZE), .OPERATION_SIZE(OPERATION_SIZE),
        .RESULT_SIZE(RESULT_SIZE), .CNT_SIZE(CNT_SIZE), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: commands and expected output words as plain queues.
    logic [41:0] cmd_q[$];
    logic [24:0] inflight_q[$];
    logic [41:0] cur_cmd = '0;
    logic [24:0] last_pushed = '0;
    logic [15:0] m_cnt = '0;
    logic [1:0]  m_op = '0;
    logic [15:0] m_a = '0;
    logic [15:0] m_b = '0;
    bit m_busy = 0, push_due = 0, m_waiting = 0;
    int wait_idx = 0, cyc = 0, ren_cyc = -10, issue_cyc = -10;

    // ALU / FIFO environment knobs
    bit alu_pend = 0, alu_never = 0;
    int alu_left = 0, fixed_delay = 0;
    logic [16:0] alu_res = '0;
    bit rst_knob = 1, run_knob = 0, full_force = 0, full_rand = 0;

    // Observed DUT events
    int dut_pushes = 0, dut_rens = 0, dut_starts = 0, dut_tmos = 0;
    int dut_ren_cyc = 0, dut_start_cyc = 0, dut_push_cyc = 0, dut_tmo_cyc = 0;
    logic [24:0] dut_push_data = '0;

    function automatic logic [16:0] alu_fn(logic [41:0] c);
        logic [15:0] a, b;
        a = c[25:10];
        b = c[41:26];
        case (c[1:0])
            2'd0:    return {1'b0, a} + {1'b0, b};
            2'd1:    return {1'b0, a} - {1'b0, b};
            2'd2:    return {1'b0, a & b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    function automatic logic [41:0] rand_cmd();
        return {16'($urandom()), 16'($urandom()), 8'($urandom()), 2'($urandom())};
    endfunction

    function automatic int pick_delay();
        if (fixed_delay > 0) return fixed_delay;
`ifdef ALU_TIMEOUT_EN
        if ($urandom_range(0, 7) == 0) return int'($urandom_range(60, 66));
`endif
        return int'($urandom_range(1, 6));
    endfunction

    function automatic void model_reset();
        inflight_q.delete();
        last_pushed = '0;
        m_cnt = '0;
        m_op = '0;
        m_a = '0;
        m_b = '0;
        m_busy = 0;
        push_due = 0;
        m_waiting = 0;
        alu_pend = 0;
        ren_cyc = -10;
        issue_cyc = -10;
    endfunction

    task automatic step();
        bit exp_r, exp_s, exp_w, exp_t;
        logic [24:0] exp_d, tmp;
        @(posedge clk);
        #1;
        cyc++;
        rst = rst_knob;
        bus.run_en = run_knob;
        bus.full_out = full_force | (full_rand & ($urandom_range(0, 2) == 0));
        bus.empty_in = (cmd_q.size() == 0);
        bus.fifo_in_data = (cyc == ren_cyc + 1) ? cur_cmd : 42'({$urandom(), $urandom()});
        bus.alu_done = 1'b0;
        bus.alu_result = 17'($urandom());
        if (cyc == issue_cyc) begin
            bus.alu_done = ($urandom_range(0, 3) == 0);
        end else if (alu_pend) begin
            if (alu_left <= 1) begin
                bus.alu_done = 1'b1;
                bus.alu_result = alu_res;
                alu_pend = 0;
            end else begin
                alu_left--;
            end
        end

        @(negedge clk);
        if (rst) begin
            check_eq("rst_r_en", bus.r_en_in, 0);
            check_eq("rst_start", bus.alu_start, 0);
            check_eq("rst_w_en", bus.w_en_out, 0);
            model_reset();
            return;
        end

        if (cyc == issue_cyc) begin
            m_op = cur_cmd[1:0];
            m_a = cur_cmd[25:10];
            m_b = cur_cmd[41:26];
        end
        exp_r = !m_busy && bus.run_en && !bus.empty_in;
        exp_s = (cyc == issue_cyc);
        exp_w = push_due && !bus.full_out;
        exp_t = 0;
`ifdef ALU_TIMEOUT_EN
        exp_t = m_waiting && !bus.alu_done && (wait_idx == TIMEOUT_CYCLES - 1);
`endif
        exp_d = (push_due && inflight_q.size() != 0) ? inflight_q[0] : last_pushed;

        check_eq("r_en_in", bus.r_en_in, exp_r);
        check_eq("alu_start", bus.alu_start, exp_s);
        check_eq("w_en_out", bus.w_en_out, exp_w);
        check_eq("timeout_err", bus.timeout_err, exp_t);
        check_eq("busy", bus.busy, m_busy);
        check_eq("op_cnt", bus.op_cnt, m_cnt);
        check_eq("fifo_out_data", bus.fifo_out_data, exp_d);
        check_eq("alu_op", bus.alu_op, m_op);
        check_eq("alu_a", bus.alu_a, m_a);
        check_eq("alu_b", bus.alu_b, m_b);
        check_eq("strobe_excl", (32'(bus.r_en_in) + 32'(bus.alu_start) + 32'(bus.w_en_out)) > 1, 0);
        check_eq("r_en_empty", bus.r_en_in && bus.empty_in, 0);

        if (bus.r_en_in === 1'b1) begin dut_rens++; dut_ren_cyc = cyc; end
        if (bus.alu_start === 1'b1) begin dut_starts++; dut_start_cyc = cyc; end
        if (bus.w_en_out === 1'b1) begin
            dut_pushes++;
            dut_push_cyc = cyc;
            dut_push_data = bus.fifo_out_data;
        end
        if (bus.timeout_err === 1'b1) begin dut_tmos++; dut_tmo_cyc = cyc; end

        if (exp_w) begin
            last_pushed = inflight_q.pop_front();
            push_due = 0;
            m_busy = 0;
            m_cnt++;
        end
        if (m_waiting) begin
            if (bus.alu_done) begin
                m_waiting = 0;
                push_due = 1;
            end else if (exp_t) begin
                tmp = inflight_q.pop_front();
                tmp[16:0] = '1;
                inflight_q.push_front(tmp);
                m_waiting = 0;
                push_due = 1;
                alu_pend = 0;
            end else begin
                wait_idx++;
            end
        end
        if (exp_s) begin
            m_waiting = 1;
            wait_idx = 0;
            if (!alu_never) begin
                alu_pend = 1;
                alu_left = pick_delay();
                alu_res = alu_fn(cur_cmd);
            end
        end
        if (exp_r) begin
            cur_cmd = cmd_q.pop_front();
            inflight_q.push_back({cur_cmd[9:2], alu_fn(cur_cmd)});
            ren_cyc = cyc;
            issue_cyc = cyc + 2;
            m_busy = 1;
        end
    endtask

    task automatic run_until_idle(string tag, int bound);
        int n = 0;
        while ((m_busy || (run_knob && cmd_q.size() != 0)) && n < bound) begin
            step();
            n++;
        end
        check_eq({tag, "_bound"}, (n >= bound), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, p0, r0, s0, t0;
        logic [15:0] c0;
        bus.run_en = 0;
        bus.empty_in = 1;
        bus.fifo_in_data = '0;
        bus.alu_done = 0;
        bus.alu_result = '0;
        bus.full_out = 0;

        // Reset
        repeat (3) step();
        rst_knob = 0;
        step();

        // Single op with minimum latency
        cmd_q.push_back({16'h0101, 16'h1234, 8'h5A, 2'd0});
        fixed_delay = 1;
        run_knob = 1;
        run_until_idle("t1", 40);
        check_eq("t1_start_lat", dut_start_cyc - dut_ren_cyc, 2);
        check_eq("t1_push_lat", dut_push_cyc - dut_ren_cyc, 4);
        check_eq("t1_data", dut_push_data, 25'h0B41335);
        step();
        check_eq("t1_op_cnt", bus.op_cnt, 1);
        fixed_delay = 0;

        // Backpressure held for 10 cycles
        p0 = dut_pushes;
        cmd_q.push_back(rand_cmd());
        full_force = 1;
        n = 0;
        while (!push_due && n < 200) begin step(); n++; end
        check_eq("t2_reach_push", push_due, 1);
        repeat (10) step();
        check_eq("t2_held", dut_pushes - p0, 0);
        full_force = 0;
        run_until_idle("t2", 40);
        check_eq("t2_one_push", dut_pushes - p0, 1);

        // Three queued commands
        c0 = m_cnt;
        cmd_q.push_back({16'h1111, 16'h2222, 8'h01, 2'd1});
        cmd_q.push_back({16'h0F0F, 16'h00FF, 8'h02, 2'd2});
        cmd_q.push_back({16'hAAAA, 16'h5555, 8'h03, 2'd3});
        run_until_idle("t3", 300);
        step();
        check_eq("t3_op_cnt", bus.op_cnt, 16'(c0 + 16'd3));
        check_eq("t3_busy", bus.busy, 0);

        // run_en dropped the cycle after alu_start
        cmd_q.push_back(rand_cmd());
        cmd_q.push_back(rand_cmd());
        fixed_delay = 3;
        s0 = dut_starts;
        n = 0;
        while (dut_starts == s0 && n < 50) begin step(); n++; end
        check_eq("t4_start_seen", dut_starts - s0, 1);
        run_knob = 0;
        r0 = dut_rens;
        p0 = dut_pushes;
        repeat (20) step();
        check_eq("t4_push", dut_pushes - p0, 1);
        check_eq("t4_no_pop", dut_rens - r0, 0);
        run_knob = 1;
        fixed_delay = 0;
        run_until_idle("t4", 200);

        // op_cnt wrap
        m_cnt = 16'hFFFF;
        force dut.op_cnt_q = 16'hFFFF;
        step();
        release dut.op_cnt_q;
        cmd_q.push_back(rand_cmd());
        run_until_idle("t5", 200);
        step();
        check_eq("t5_wrap", bus.op_cnt, 16'h0000);

        // Reset during WAIT discards the op
        cmd_q.push_back(rand_cmd());
        alu_never = 1;
        n = 0;
        while (!(m_waiting && wait_idx >= 2) && n < 100) begin step(); n++; end
        check_eq("t6_reach_wait", m_waiting, 1);
        p0 = dut_pushes;
        rst_knob = 1;
        step();
        rst_knob = 0;
        alu_never = 0;
        step();
        check_eq("t6_busy", bus.busy, 0);
        check_eq("t6_op_cnt", bus.op_cnt, 0);
        check_eq("t6_data", bus.fifo_out_data, 0);
        repeat (10) step();
        check_eq("t6_no_push", dut_pushes - p0, 0);

        // ALU never completes
        cmd_q.push_back({16'h0000, 16'h0000, 8'hC3, 2'd0});
        alu_never = 1;
        t0 = dut_tmos;
        p0 = dut_pushes;
`ifdef ALU_TIMEOUT_EN
        run_until_idle("t7", 200);
        check_eq("t7_tmo_pulses", dut_tmos - t0, 1);
        check_eq("t7_tmo_wait", dut_tmo_cyc - dut_start_cyc, TIMEOUT_CYCLES);
        check_eq("t7_data", dut_push_data, {8'hC3, 17'h1FFFF});
        check_eq("t7_push", dut_pushes - p0, 1);
        alu_never = 0;
`else
        repeat (150) step();
        check_eq("t7_busy", bus.busy, 1);
        check_eq("t7_no_push", dut_pushes - p0, 0);
        check_eq("t7_no_tmo", dut_tmos - t0, 0);
        alu_never = 0;
        rst_knob = 1;
        step();
        rst_knob = 0;
        step();
`endif

        // Randomized traffic with backpressure and run_en toggling
        full_rand = 1;
        for (int i = 0; i < 250; i++) begin
            cmd_q.push_back(rand_cmd());
            repeat ($urandom_range(0, 6)) step();
            run_knob = ($urandom_range(0, 9) != 0);
        end
        run_knob = 1;
        run_until_idle("t8", 30000);
        full_rand = 0;
        step();
        check_eq("t8_op_cnt", bus.op_cnt, m_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
